// File: rtl/watch_pkg.sv
// Shared definitions for the sport-watch controller: mode index constants,
// the default display field width and the action-button press FSM encoding.
package watch_pkg;

  localparam int FIELD_W_DEF    = 7;

  localparam int MODE_CLOCK     = 0;
  localparam int MODE_SETUP     = 1;
  localparam int MODE_ALARM     = 2;
  localparam int MODE_COUNTDOWN = 3;
  localparam int MODE_COUNTUP   = 4;

  typedef enum logic [1:0] {
    PRESS_IDLE      = 2'd0,
    PRESS_HELD      = 2'd1,
    PRESS_LONG_DONE = 2'd2,
    PRESS_ABORT     = 2'd3
  } press_state_e;

endpackage

// File: rtl/mode_sequencer_if.sv
// Button, per-mode field and display/mode-status bundle of mode_sequencer.
// master drives buttons and fields; slave is the sequencer itself.
interface mode_sequencer_if #(
  parameter int NUM_MODES = 5,
  parameter int FIELD_W   = watch_pkg::FIELD_W_DEF
) ();

  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;

  logic                           btn_mode;
  logic                           btn_action;
  logic [NUM_MODES*4*FIELD_W-1:0] fields_in;
  logic [MODE_W-1:0]              mode_idx;
  logic [NUM_MODES-1:0]           mode_onehot;
  logic [NUM_MODES-1:0]           run;
  logic [NUM_MODES-1:0]           clr_pulse;
  logic [FIELD_W-1:0]             disp_ll;
  logic [FIELD_W-1:0]             disp_lr;
  logic [FIELD_W-1:0]             disp_rl;
  logic [FIELD_W-1:0]             disp_rr;

  modport master (
    output btn_mode, btn_action, fields_in,
    input  mode_idx, mode_onehot, run, clr_pulse,
    input  disp_ll, disp_lr, disp_rl, disp_rr
  );

  modport slave (
    input  btn_mode, btn_action, fields_in,
    output mode_idx, mode_onehot, run, clr_pulse,
    output disp_ll, disp_lr, disp_rl, disp_rr
  );

endinterface

// File: rtl/press_classifier.sv
// Classifies a held action button into short and long presses.
// Events are decoded from the registered state so the caller acts on them at the same edge.
module press_classifier
  import watch_pkg::*;
#(
  parameter int SHORT_MIN_CYCLES = 100,
  parameter int LONG_CYCLES      = 250000000,
  parameter int CNT_W            = 28
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic abort,
  output logic short_evt,
  output logic long_evt
);

  localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(SHORT_MIN_CYCLES);
  localparam logic [CNT_W-1:0] LONG_AT   = CNT_W'(LONG_CYCLES);

  press_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             rel_seen_q;

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign short_evt = (state_q == PRESS_HELD) && !btn && (cnt_q >= SHORT_MIN);
  assign long_evt  = (state_q == PRESS_HELD) && btn && (cnt_inc == LONG_AT);

  // rel_seen_q clears on reset, so a button held through reset must be released before it counts
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= PRESS_IDLE;
      cnt_q      <= '0;
      rel_seen_q <= 1'b0;
    end else begin
      rel_seen_q <= ~btn;
      case (state_q)
        PRESS_IDLE: begin
          if (btn && rel_seen_q) begin
            state_q <= PRESS_HELD;
            cnt_q   <= CNT_W'(1);
          end
        end
        PRESS_HELD: begin
          if (!btn) begin
            state_q <= PRESS_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (long_evt)   state_q <= PRESS_LONG_DONE;
            else if (abort) state_q <= PRESS_ABORT;
          end
        end
        PRESS_LONG_DONE: begin
          if (!btn) begin
            state_q <= PRESS_IDLE;
            cnt_q   <= '0;
          end else if (abort) begin
            state_q <= PRESS_ABORT;
          end
        end
        default: begin
          if (!btn) begin
            state_q <= PRESS_IDLE;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Sport-watch mode/button controller: mode cycling, per-mode run flags, clear pulses, display mux.
// Optional MODE_AUTORETURN_EN: return to the clock mode after IDLE_CYCLES without button activity.
module mode_sequencer
  import watch_pkg::*;
#(
  parameter int              NUM_MODES        = 5,
  parameter int              FIELD_W          = FIELD_W_DEF,
  parameter int              SHORT_MIN_CYCLES = 100,
  parameter int              LONG_CYCLES      = 250000000,
  parameter int              CNT_W            = 28,
  parameter longint unsigned IDLE_CYCLES      = 64'd3000000000
) (
  input logic             clk,
  input logic             reset,
  mode_sequencer_if.slave bus
);

  localparam int                   MODE_W    = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
  localparam int                   SLOT_W    = 4 * FIELD_W;
  localparam logic [MODE_W-1:0]    LAST_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0]    HOME_MODE = MODE_W'(MODE_CLOCK);
  localparam logic [NUM_MODES-1:0] ONE       = NUM_MODES'(1);

  logic                 btn_mode_q;
  logic [MODE_W-1:0]    mode_q, mode_d;
  logic [NUM_MODES-1:0] onehot_q;
  logic [NUM_MODES-1:0] run_q, run_d;
  logic [NUM_MODES-1:0] clr_q, clr_d;
  logic [FIELD_W-1:0]   ll_q, lr_q, rl_q, rr_q;
  logic [SLOT_W-1:0]    slot;
  logic                 mode_edge;
  logic                 short_evt;
  logic                 long_evt;
  logic                 timeout;

  assign mode_edge = bus.btn_mode & ~btn_mode_q;

  press_classifier #(
    .SHORT_MIN_CYCLES(SHORT_MIN_CYCLES),
    .LONG_CYCLES     (LONG_CYCLES),
    .CNT_W           (CNT_W)
  ) u_press (
    .clk      (clk),
    .reset    (reset),
    .btn      (bus.btn_action),
    .abort    (mode_edge),
    .short_evt(short_evt),
    .long_evt (long_evt)
  );

`ifdef MODE_AUTORETURN_EN
  localparam int                IDLE_W  = $clog2(IDLE_CYCLES + 64'd1);
  localparam logic [IDLE_W-1:0] IDLE_AT = IDLE_W'(IDLE_CYCLES);

  logic [IDLE_W-1:0] idle_q, idle_d;

  // Saturates in the clock mode so it never wraps while nothing needs to happen
  always_comb begin
    idle_d  = idle_q;
    timeout = 1'b0;
    if (bus.btn_mode || bus.btn_action) idle_d = '0;
    else if (idle_q != IDLE_AT)         idle_d = idle_q + 1'b1;
    if ((idle_d == IDLE_AT) && (mode_q != HOME_MODE)) begin
      timeout = 1'b1;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unused_idle;
  assign unused_idle = ^IDLE_CYCLES;
  assign timeout     = 1'b0;
`endif

  // Press events act on the mode in force this cycle, before any advance takes effect
  always_comb begin
    mode_d = mode_q;
    if (mode_edge) mode_d = (mode_q == LAST_MODE) ? '0 : mode_q + 1'b1;
    if (timeout)   mode_d = HOME_MODE;
    run_d = run_q;
    clr_d = '0;
    if (short_evt) run_d[mode_q] = ~run_q[mode_q];
    if (long_evt) begin
      run_d[mode_q] = 1'b0;
      clr_d[mode_q] = 1'b1;
    end
  end

  always_comb begin
    slot = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (mode_d == MODE_W'(m)) slot = bus.fields_in[m*SLOT_W +: SLOT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_mode_q <= 1'b0;
      mode_q     <= HOME_MODE;
      onehot_q   <= ONE;
      run_q      <= '0;
      clr_q      <= '0;
      ll_q       <= '0;
      lr_q       <= '0;
      rl_q       <= '0;
      rr_q       <= '0;
    end else begin
      btn_mode_q <= bus.btn_mode;
      mode_q     <= mode_d;
      onehot_q   <= ONE << mode_d;
      run_q      <= run_d;
      clr_q      <= clr_d;
      ll_q       <= slot[4*FIELD_W-1 -: FIELD_W];
      lr_q       <= slot[3*FIELD_W-1 -: FIELD_W];
      rl_q       <= slot[2*FIELD_W-1 -: FIELD_W];
      rr_q       <= slot[FIELD_W-1:0];
    end
  end

  assign bus.mode_idx    = mode_q;
  assign bus.mode_onehot = onehot_q;
  assign bus.run         = run_q;
  assign bus.clr_pulse   = clr_q;
  assign bus.disp_ll     = ll_q;
  assign bus.disp_lr     = lr_q;
  assign bus.disp_rl     = rl_q;
  assign bus.disp_rr     = rr_q;

endmodule
